// File: rtl/crg_clk_seq.sv
// Enable/select sequencer for the clock/reset generator: staggered bring-up after
// MMCM lock, glitch-safe clk1 source switching, and full restart on lock loss.
module crg_clk_seq #(
    parameter int LOCK_STABLE_CYC = 64,
    parameter int STAGGER_CYC     = 8,
    parameter int GATE_CYC        = 4,
    parameter int SETTLE_CYC      = 16,
    parameter int CNT_W           = 8
) (
    input  logic       clk_src,
    input  logic       rst_n_sys,
    input  logic       mmcm_locked,
    input  logic [3:0] run_en,
    input  logic       sw_req,
    input  logic       sw_sel,
    output logic       sw_ack,
    output logic       clk_phy_en,
    output logic       clk1_en,
    output logic       clk2_en,
    output logic       clk3_en,
    output logic       clk1_sel,
    output logic [2:0] seq_state,
    output logic       lock_lost,
    input  logic       lock_lost_clr
);

    typedef enum logic [2:0] {
        LOCK_WAIT = 3'd0,
        BRINGUP   = 3'd1,
        RUN       = 3'd2,
        GATE      = 3'd3,
        SWITCH    = 3'd4
    } seq_state_t;

    localparam logic [CNT_W-1:0] LOCK_TARGET  = CNT_W'(LOCK_STABLE_CYC);
    localparam logic [CNT_W-1:0] STAGGER_LOAD = CNT_W'(STAGGER_CYC - 1);
    localparam logic [CNT_W-1:0] GATE_LOAD    = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYC - 1);

    seq_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       step_reg, step_next;
    logic [3:0]       en_reg, en_next;
    logic             clk1_sel_reg, clk1_sel_next;
    logic             sel_latch_reg, sel_latch_next;
    logic             sw_ack_reg, sw_ack_next;
    logic             lock_lost_reg, lock_lost_next;
    logic             lost_set;
    logic [1:0]       sync_reg;
    logic             locked_s;
    logic [1:0]       step_idx;
    logic [3:0]       en_gated;

    // Two-flop synchronizer for the asynchronous lock indication
    always_ff @(posedge clk_src or negedge rst_n_sys) begin
        if (!rst_n_sys) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], mmcm_locked};
        end
    end

    assign locked_s = sync_reg[1];
    assign step_idx = step_reg + 2'd1;

    // run_en with clk1 forced off, used while clk1's mux is being switched
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_gated
            if (gi == 1) begin : g_clk1
                assign en_gated[gi] = 1'b0;
            end else begin : g_other
                assign en_gated[gi] = run_en[gi];
            end
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        step_next      = step_reg;
        en_next        = en_reg;
        clk1_sel_next  = clk1_sel_reg;
        sel_latch_next = sel_latch_reg;
        sw_ack_next    = 1'b0;
        lost_set       = 1'b0;

        if ((state_reg != LOCK_WAIT) && !locked_s) begin
            // Lock loss wins over everything; clk1_sel is deliberately left alone
            state_next = LOCK_WAIT;
            cnt_next   = '0;
            step_next  = '0;
            en_next    = '0;
            lost_set   = 1'b1;
        end else begin
            unique case (state_reg)
                LOCK_WAIT: begin
                    en_next = '0;
                    if (!locked_s) begin
                        cnt_next = '0;
                    end else if (cnt_reg == LOCK_TARGET) begin
                        state_next = BRINGUP;
                        cnt_next   = STAGGER_LOAD;
                        step_next  = '0;
                        en_next[0] = run_en[0];
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                BRINGUP: begin
                    if (cnt_reg == '0) begin
                        en_next[step_idx] = run_en[step_idx];
                        cnt_next          = STAGGER_LOAD;
                        step_next         = step_reg + 2'd1;
                        if (step_reg == 2'd2) begin
                            state_next = RUN;
                        end
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                RUN: begin
                    en_next = run_en;
                    // The ack cycle itself is never an accept, so a held request is not re-serviced
                    if (sw_req && !sw_ack_reg) begin
                        sel_latch_next = sw_sel;
                        if (sw_sel == clk1_sel_reg) begin
                            sw_ack_next = 1'b1;
                        end else begin
                            state_next = GATE;
                            cnt_next   = GATE_LOAD;
                            en_next    = en_gated;
                        end
                    end
                end
                GATE: begin
                    en_next = en_gated;
                    if (cnt_reg == '0) begin
                        state_next    = SWITCH;
                        cnt_next      = SETTLE_LOAD;
                        clk1_sel_next = sel_latch_reg;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                SWITCH: begin
                    en_next = en_gated;
                    if (cnt_reg == '0) begin
                        state_next  = RUN;
                        en_next     = run_en;
                        sw_ack_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - 1'b1;
                    end
                end
                default: begin
                    state_next = LOCK_WAIT;
                    cnt_next   = '0;
                    en_next    = '0;
                end
            endcase
        end

        // A set on the same cycle as a clear leaves the flag set
        lock_lost_next = (lock_lost_reg & ~lock_lost_clr) | lost_set;
    end

    always_ff @(posedge clk_src or negedge rst_n_sys) begin
        if (!rst_n_sys) begin
            state_reg     <= LOCK_WAIT;
            cnt_reg       <= '0;
            step_reg      <= '0;
            en_reg        <= '0;
            clk1_sel_reg  <= 1'b0;
            sel_latch_reg <= 1'b0;
            sw_ack_reg    <= 1'b0;
            lock_lost_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            step_reg      <= step_next;
            en_reg        <= en_next;
            clk1_sel_reg  <= clk1_sel_next;
            sel_latch_reg <= sel_latch_next;
            sw_ack_reg    <= sw_ack_next;
            lock_lost_reg <= lock_lost_next;
        end
    end

    assign clk_phy_en = en_reg[0];
    assign clk1_en    = en_reg[1];
    assign clk2_en    = en_reg[2];
    assign clk3_en    = en_reg[3];
    assign clk1_sel   = clk1_sel_reg;
    assign sw_ack     = sw_ack_reg;
    assign lock_lost  = lock_lost_reg;
    assign seq_state  = state_reg;

endmodule

// File: tb/tb_crg_clk_seq.sv
// Self-checking bench for crg_clk_seq: expected behaviour is derived from event
// times (lock window, stagger, gate/settle durations) rather than a state machine.
module tb_crg_clk_seq;

    localparam int LOCK_STABLE_CYC = 64;
    localparam int STAGGER_CYC     = 8;
    localparam int GATE_CYC        = 4;
    localparam int SETTLE_CYC      = 16;
    localparam int CNT_W           = 8;
    localparam int SYNC_LAT        = 2;

    logic       clk_src = 1'b0;
    logic       rst_n_sys = 1'b0;
    logic       mmcm_locked = 1'b0;
    logic [3:0] run_en = 4'h0;
    logic       sw_req = 1'b0;
    logic       sw_sel = 1'b0;
    logic       lock_lost_clr = 1'b0;
    logic       sw_ack;
    logic       clk_phy_en, clk1_en, clk2_en, clk3_en;
    logic       clk1_sel;
    logic [2:0] seq_state;
    logic       lock_lost;
    logic [3:0] en_vec;

    int   checks = 0;
    int   errors = 0;
    logic model_sel = 1'b0;

    assign en_vec = {clk3_en, clk2_en, clk1_en, clk_phy_en};

    always #5 clk_src = ~clk_src;

    crg_clk_seq #(
        .LOCK_STABLE_CYC(LOCK_STABLE_CYC),
        .STAGGER_CYC    (STAGGER_CYC),
        .GATE_CYC       (GATE_CYC),
        .SETTLE_CYC     (SETTLE_CYC),
        .CNT_W          (CNT_W)
    ) dut (
        .clk_src      (clk_src),
        .rst_n_sys    (rst_n_sys),
        .mmcm_locked  (mmcm_locked),
        .run_en       (run_en),
        .sw_req       (sw_req),
        .sw_sel       (sw_sel),
        .sw_ack       (sw_ack),
        .clk_phy_en   (clk_phy_en),
        .clk1_en      (clk1_en),
        .clk2_en      (clk2_en),
        .clk3_en      (clk3_en),
        .clk1_sel     (clk1_sel),
        .seq_state    (seq_state),
        .lock_lost    (lock_lost),
        .lock_lost_clr(lock_lost_clr)
    );

    task automatic tick();
        @(posedge clk_src);
        #1;
    endtask

    task automatic do_reset();
        rst_n_sys = 1'b0;
        mmcm_locked = 1'b0;
        run_en = 4'h0;
        sw_req = 1'b0;
        sw_sel = 1'b0;
        lock_lost_clr = 1'b0;
        repeat (3) tick();
        rst_n_sys = 1'b1;
        repeat (2) tick();
        model_sel = 1'b0;
    endtask

    task automatic test_reset();
        mmcm_locked = 1'b1;
        run_en = 4'hF;
        repeat (3) tick();
        checks++;
        if (en_vec !== 4'h0) begin errors++; $display("FAIL reset_en got %b want 0000", en_vec); end
        checks++;
        if (seq_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", seq_state); end
        checks++;
        if ({sw_ack, clk1_sel, lock_lost} !== 3'b000) begin
            errors++; $display("FAIL reset_misc ack/sel/lost got %b want 000", {sw_ack, clk1_sel, lock_lost});
        end
        $display("reset: en=%b state=%0d", en_vec, seq_state);
    endtask

    // glitch_edge < 0: lock stays high from edge 0; otherwise that one edge samples lock low
    task automatic test_bringup(input logic [3:0] re, input int glitch_edge);
        int b;
        logic [3:0] exp_en;
        logic [2:0] exp_state;
        do_reset();
        run_en = re;
        // Bring-up starts once the last unbroken lock run has lasted the stable window plus sync latency
        b = ((glitch_edge < 0) ? 0 : glitch_edge + 1) + LOCK_STABLE_CYC + SYNC_LAT;
        for (int n = 0; n <= b + 3 * STAGGER_CYC + 2; n++) begin
            mmcm_locked = (n == glitch_edge) ? 1'b0 : 1'b1;
            tick();
            exp_en[0] = (n >= b) & re[0];
            exp_en[1] = (n >= b + STAGGER_CYC) & re[1];
            exp_en[2] = (n >= b + 2 * STAGGER_CYC) & re[2];
            exp_en[3] = (n >= b + 3 * STAGGER_CYC) & re[3];
            exp_state = (n < b) ? 3'd0 : (n < b + 3 * STAGGER_CYC) ? 3'd1 : 3'd2;
            checks++;
            if (en_vec !== exp_en) begin
                errors++; $display("FAIL bringup_en edge %0d got %b want %b", n, en_vec, exp_en);
            end
            checks++;
            if (seq_state !== exp_state) begin
                errors++; $display("FAIL bringup_state edge %0d got %0d want %0d", n, seq_state, exp_state);
            end
        end
        checks++;
        if ({sw_ack, lock_lost, clk1_sel} !== 3'b000) begin
            errors++; $display("FAIL bringup_misc ack/lost/sel got %b want 000", {sw_ack, lock_lost, clk1_sel});
        end
        $display("bringup: run_en=%b glitch=%0d phy_edge=%0d en=%b state=%0d", re, glitch_edge, b, en_vec, seq_state);
    endtask

    task automatic test_run_en_late();
        checks++;
        if (en_vec !== 4'b0101) begin errors++; $display("FAIL late_pre got %b want 0101", en_vec); end
        run_en = 4'b1101;
        tick();
        checks++;
        if (en_vec !== 4'b1101) begin errors++; $display("FAIL late_clk3 got %b want 1101", en_vec); end
        $display("run_en_late: en=%b", en_vec);
    endtask

    task automatic test_run_track();
        logic [3:0] drv;
        for (int n = 0; n < 16; n++) begin
            drv = 4'($urandom);
            run_en = drv;
            tick();
            checks++;
            if (en_vec !== drv || seq_state !== 3'd2) begin
                errors++; $display("FAIL run_track en=%b state=%0d want en=%b state=2", en_vec, seq_state, drv);
            end
            $display("run_track: run_en=%b en=%b", drv, en_vec);
        end
        run_en = 4'hF;
        tick();
    endtask

    task automatic test_switch(input bit rand_en, input bit drop_mid);
        logic       new_sel, old_sel, exp_sel, exp_ack;
        logic [3:0] exp_en;
        logic [2:0] exp_state;
        int         drop_k;
        int         done_k;
        done_k = GATE_CYC + SETTLE_CYC;
        old_sel = model_sel;
        new_sel = ~model_sel;
        drop_k = drop_mid ? int'($urandom_range(1, done_k - 1)) : -1;
        repeat ($urandom_range(0, 3)) tick();
        sw_sel = new_sel;
        sw_req = 1'b1;
        for (int k = 0; k <= done_k + 1; k++) begin
            if (k == drop_k || k == done_k + 1) sw_req = 1'b0;
            if (k > 0) sw_sel = 1'($urandom);
            if (rand_en) run_en = 4'($urandom) | 4'b0010;
            tick();
            exp_state = (k < GATE_CYC) ? 3'd3 : (k < done_k) ? 3'd4 : 3'd2;
            exp_en = run_en;
            if (k < done_k) exp_en[1] = 1'b0;
            exp_sel = (k < GATE_CYC) ? old_sel : new_sel;
            exp_ack = (k == done_k);
            checks++;
            if (en_vec !== exp_en) begin errors++; $display("FAIL switch_en k=%0d got %b want %b", k, en_vec, exp_en); end
            checks++;
            if (seq_state !== exp_state) begin errors++; $display("FAIL switch_state k=%0d got %0d want %0d", k, seq_state, exp_state); end
            checks++;
            if (clk1_sel !== exp_sel) begin errors++; $display("FAIL switch_sel k=%0d got %b want %b", k, clk1_sel, exp_sel); end
            checks++;
            if (sw_ack !== exp_ack) begin errors++; $display("FAIL switch_ack k=%0d got %b want %b", k, sw_ack, exp_ack); end
        end
        model_sel = new_sel;
        run_en = 4'hF;
        tick();
        $display("switch: rand_en=%0d drop=%0d sel %b->%b en=%b", rand_en, drop_k, old_sel, clk1_sel, en_vec);
    endtask

    task automatic test_same_sel();
        repeat ($urandom_range(0, 3)) tick();
        sw_sel = model_sel;
        sw_req = 1'b1;
        tick();
        checks++;
        if (sw_ack !== 1'b1 || clk1_en !== 1'b1 || seq_state !== 3'd2) begin
            errors++; $display("FAIL same_sel_ack ack/en1/state got %b/%b/%0d want 1/1/2", sw_ack, clk1_en, seq_state);
        end
        sw_req = 1'b0;
        tick();
        checks++;
        if (sw_ack !== 1'b0 || clk1_en !== 1'b1 || clk1_sel !== model_sel) begin
            errors++; $display("FAIL same_sel_after ack/en1/sel got %b/%b/%b want 0/1/%b", sw_ack, clk1_en, clk1_sel, model_sel);
        end
        $display("same_sel: sel=%b ack=%b en=%b", clk1_sel, sw_ack, en_vec);
    endtask

    task automatic test_lock_loss_switch();
        logic       new_sel, old_sel, exp_sel, exp_ack, exp_lost;
        logic [3:0] exp_en;
        logic [2:0] exp_state;
        int         lk, hi, b, d;
        old_sel = model_sel;
        new_sel = ~model_sel;
        lk = $urandom_range(GATE_CYC, GATE_CYC + SETTLE_CYC - 3);
        hi = lk + int'($urandom_range(1, 4));
        b  = hi + LOCK_STABLE_CYC + SYNC_LAT;
        d  = lk + SYNC_LAT;
        run_en = 4'hF;
        sw_sel = new_sel;
        sw_req = 1'b1;
        for (int k = 0; k <= b + 3 * STAGGER_CYC + 2; k++) begin
            mmcm_locked = (k >= lk && k < hi) ? 1'b0 : 1'b1;
            lock_lost_clr = (k == d);
            if (k == b + 3 * STAGGER_CYC + 2) sw_req = 1'b0;
            tick();
            exp_ack = 1'b0;
            exp_lost = (k >= d);
            if (k < d) begin
                exp_state = (k < GATE_CYC) ? 3'd3 : 3'd4;
                exp_en = 4'b1101;
                exp_sel = (k < GATE_CYC) ? old_sel : new_sel;
            end else begin
                exp_sel = new_sel;
                exp_en[0] = (k >= b);
                exp_en[1] = (k >= b + STAGGER_CYC);
                exp_en[2] = (k >= b + 2 * STAGGER_CYC);
                exp_en[3] = (k >= b + 3 * STAGGER_CYC);
                exp_state = (k < b) ? 3'd0 : (k < b + 3 * STAGGER_CYC) ? 3'd1 : 3'd2;
                // The held request is accepted on the first RUN cycle; select already matches
                exp_ack = (k == b + 3 * STAGGER_CYC + 1);
            end
            checks++;
            if (en_vec !== exp_en) begin errors++; $display("FAIL loss_en k=%0d got %b want %b", k, en_vec, exp_en); end
            checks++;
            if (seq_state !== exp_state) begin errors++; $display("FAIL loss_state k=%0d got %0d want %0d", k, seq_state, exp_state); end
            checks++;
            if (sw_ack !== exp_ack) begin errors++; $display("FAIL loss_ack k=%0d got %b want %b", k, sw_ack, exp_ack); end
            checks++;
            if (lock_lost !== exp_lost || clk1_sel !== exp_sel) begin
                errors++; $display("FAIL loss_flag k=%0d lost/sel got %b/%b want %b/%b", k, lock_lost, clk1_sel, exp_lost, exp_sel);
            end
        end
        lock_lost_clr = 1'b0;
        model_sel = new_sel;
        $display("lock_loss: low_edge=%0d relock_edge=%0d lost=%b sel=%b en=%b", lk, hi, lock_lost, clk1_sel, en_vec);
    endtask

    task automatic test_lock_lost_clr();
        checks++;
        if (lock_lost !== 1'b1) begin errors++; $display("FAIL clr_pre got %b want 1", lock_lost); end
        lock_lost_clr = 1'b1;
        tick();
        lock_lost_clr = 1'b0;
        checks++;
        if (lock_lost !== 1'b0) begin errors++; $display("FAIL clr_post got %b want 0", lock_lost); end
        tick();
        checks++;
        if (lock_lost !== 1'b0) begin errors++; $display("FAIL clr_hold got %b want 0", lock_lost); end
        $display("lock_lost_clr: lost=%b", lock_lost);
    endtask

    task automatic test_async_reset();
        #3;
        rst_n_sys = 1'b0;
        #1;
        checks++;
        if ({en_vec, clk1_sel, sw_ack, lock_lost} !== 7'd0 || seq_state !== 3'd0) begin
            errors++; $display("FAIL async_reset en=%b sel=%b ack=%b lost=%b state=%0d want all 0",
                               en_vec, clk1_sel, sw_ack, lock_lost, seq_state);
        end
        tick();
        rst_n_sys = 1'b1;
        $display("async_reset: en=%b state=%0d sel=%b", en_vec, seq_state, clk1_sel);
    endtask

    initial begin
        test_reset();
        test_bringup(4'hF, -1);
        test_bringup(4'hF, 32);
        test_bringup(4'hF, int'($urandom_range(5, 60)));
        test_bringup(4'b0101, -1);
        test_run_en_late();
        test_bringup(4'hF, -1);
        test_run_track();
        test_switch(1'b0, 1'b0);
        test_switch(1'b1, 1'b0);
        test_switch(1'b1, 1'b1);
        test_same_sel();
        test_switch(1'b0, 1'b1);
        test_same_sel();
        test_lock_loss_switch();
        test_lock_lost_clr();
        test_switch(1'b1, 1'b0);
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/crg_clk_seq.md
Name: crg_clk_seq

Overview:
- Control-side sequencer that drives the enable and select inputs of the clock/reset generator.
- After reset and MMCM lock it brings up the gated clocks in a fixed staggered order: clk_phy, clk1, clk2, clk3.
- It performs glitch-safe runtime switching of clk1's mux source: gate off, switch, settle, re-enable.
- On MMCM lock loss it drops all clock enables and re-runs the bring-up sequence.
- Runs on the free-running source clock.

Parameters:
- LOCK_STABLE_CYC, 64: consecutive cycles synchronized lock must stay high before bring-up starts (1..2^CNT_W-1).
- STAGGER_CYC, 8: cycles between successive clock enables during bring-up (>=1).
- GATE_CYC, 4: cycles clk1_en is held low before clk1_sel changes (>=1).
- SETTLE_CYC, 16: cycles after the clk1_sel change before clk1_en is restored (>=1).
- CNT_W, 8: width of the shared down-counter.

Ports:
- clk_src, in, 1: free-running source clock; the only clock.
- rst_n_sys, in, 1: asynchronous, active-low reset.
- mmcm_locked, in, 1: MMCM lock status; asynchronous; synchronized internally by 2 flops.
- run_en, in, 4: software enable mask; bit0 clk_phy, bit1 clk1, bit2 clk2, bit3 clk3.
- sw_req, in, 1: clk1 source switch request; level, held until sw_ack.
- sw_sel, in, 1: requested clk1 mux select; sampled when sw_req is accepted.
- sw_ack, out, 1: one-cycle pulse when the switch request completes.
- clk_phy_en, out, 1: drives the CRG clk_phy_en input.
- clk1_en, out, 1: drives the CRG clk1_en input.
- clk2_en, out, 1: drives the CRG clk2_en input.
- clk3_en, out, 1: drives the CRG clk3_en input.
- clk1_sel, out, 1: drives the CRG clk1_sel input.
- seq_state, out, 3: current FSM state encoding.
- lock_lost, out, 1: sticky flag; set on lock loss in any state after LOCK_WAIT.
- lock_lost_clr, in, 1: synchronous clear for lock_lost.

Behaviour:
- Reset values:
  - All outputs 0; seq_state = LOCK_WAIT (0).
  - Counter 0; sync flops 0; latched select 0.
- All outputs are registered. The *_en outputs change only on clk_src edges.
- locked_s is mmcm_locked after two flops.
- Counter rule: each timed state loads N-1 on entry and advances when the counter reaches 0, so the state lasts exactly N cycles.
- LOCK_WAIT (0):
  - All enables 0.
  - Counter counts consecutive cycles with locked_s=1; any locked_s=0 restarts the count.
  - After LOCK_STABLE_CYC consecutive high cycles, go to BRINGUP.
- BRINGUP (1):
  - On entry, clk_phy_en <= run_en[0].
  - Every STAGGER_CYC cycles the next enable turns on, in order clk1, clk2, clk3; each enable is ANDed with its run_en bit.
  - Go to RUN on the same edge that enables clk3.
  - sw_req is not accepted in this state.
- RUN (2):
  - Each *_en tracks its run_en bit with 1 cycle of latency.
  - Accept a request when sw_req=1 and sw_ack=0; latch sw_sel at accept.
  - If latched sel equals clk1_sel: pulse sw_ack on the next cycle and stay in RUN.
  - Otherwise go to GATE.
- GATE (3):
  - clk1_en=0 for GATE_CYC cycles; other enables keep tracking run_en.
  - Then go to SWITCH.
- SWITCH (4):
  - On entry, clk1_sel <= latched sel; hold for SETTLE_CYC cycles with clk1_en=0.
  - Then go to RUN with clk1_en <= run_en[1] and a one-cycle sw_ack on the same edge.
- Lock loss (locked_s=0 in BRINGUP, RUN, GATE or SWITCH):
  - Next edge: all enables 0, lock_lost=1, state LOCK_WAIT, counter cleared.
  - Any in-flight switch is aborted without sw_ack.
  - clk1_sel keeps its current value.
  - Lock loss has priority over every other event on the same cycle.
- Pending request after recovery: if sw_req is still high when RUN is re-entered after recovery, it is serviced normally.
- lock_lost:
  - Cleared by lock_lost_clr=1.
  - A set and a clear on the same cycle leave it set.
- sw_req deasserted mid-switch: ignored; the sequence completes and sw_ack still pulses. The requester must keep sw_req low for at least 1 cycle after sw_ack before a new request.
- Asynchronous reset at any time returns all outputs to their reset values immediately.

Test Plan:
- Reset release with mmcm_locked=1 and run_en=4'hF:
  - clk_phy_en rises 66 cycles after the first edge that samples locked high.
  - clk1_en, clk2_en and clk3_en rise at +8, +16 and +24 cycles after that.
  - seq_state=2 at +24.
- Lock glitch during LOCK_WAIT: pull mmcm_locked low for 1 cycle at stable count 30 -> count restarts, and bring-up begins 64 stable cycles after the restart.
- Switch clk1 in RUN with sw_sel=1 and clk1_sel=0:
  - clk1_en falls 1 cycle after accept.
  - clk1_sel rises 4 cycles later.
  - clk1_en restores and sw_ack pulses for 1 cycle 16 cycles after that.
  - clk2_en and clk3_en stay high throughout.
- Same-select request: sw_sel == clk1_sel -> sw_ack on the cycle after accept; clk1_en never drops.
- Lock loss mid-SWITCH:
  - Next edge after locked_s falls: all enables 0, lock_lost=1, no sw_ack.
  - After re-lock and bring-up, the still-high sw_req completes with sw_ack.
- run_en=4'b0101 during bring-up: only clk_phy_en and clk2_en assert. Setting run_en[3]=1 later in RUN raises clk3_en 1 cycle later.
